pwm_timer: RTL and testbench
============================

PWM_TIMER -- requirements
Module: pwm_timer

Interface
REQ-001 SHALL have parameter: WIDTH, 16, width of period/duty/count datapath.
REQ-002 SHALL have port: i_clk  input  1  system clock, rising-edge active.
REQ-003 SHALL have port: i_rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: i_slow_clk  input  1  divided clock from clock_down, sampled as data in i_clk domain.
REQ-005 SHALL have port: i_en  input  1  level enable from reg_file.
REQ-006 SHALL have port: i_mode  input  1  0 = continuous PWM, 1 = one-shot timer.
REQ-007 SHALL have port: i_period  input  WIDTH  period in ticks.
REQ-008 SHALL have port: i_duty  input  WIDTH  high time in ticks.
REQ-009 SHALL have port: i_irq_clr  input  1  single-cycle interrupt clear.
REQ-010 SHALL have port: o_pwm  output  1  PWM / timer output.
REQ-011 SHALL have port: o_irq  output  1  sticky period-end interrupt.
REQ-012 SHALL have port: o_count  output  WIDTH  current tick count.
REQ-013 SHALL have port: o_busy  output  1  high while in RUN.

Function
REQ-014 SHALL register i_slow_clk into slow_q each i_clk; tick = i_slow_clk & ~slow_q; no i_clk-domain logic clocked by i_slow_clk.
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 IDLE: if i_en=1 and i_period!=0, latch i_period/i_duty/i_mode into shadow registers, clear count, go RUN next cycle; i_period=0 keeps IDLE.
REQ-017 RUN: on tick, if count == period_sh-1, count wraps to 0 and period-end event fires; else count increments by 1; no tick -> count holds.
REQ-018 RUN, mode_sh=0: period-end reloads shadows from i_period/i_duty/i_mode; mid-period input changes have no effect until then.
REQ-019 RUN, mode_sh=1: period-end transitions to DONE; count holds 0.
REQ-020 DONE: o_pwm=0; remains until i_en=0, then IDLE.
REQ-021 i_en=0 in RUN or DONE SHALL return to IDLE next i_clk, clearing count; no period-end event fires.
REQ-022 o_pwm SHALL equal (state==RUN) && (count < duty_sh), driven from registers only; duty_sh=0 -> always 0, duty_sh>=period_sh -> always 1 in RUN.
REQ-023 o_busy SHALL be 1 exactly when state==RUN; o_count SHALL mirror count.
REQ-024 Tick latency: count changes on the first i_clk edge after i_slow_clk is sampled high following a low sample.
REQ-025 Count arithmetic SHALL be WIDTH-bit unsigned; period_sh=1 wraps every tick with o_pwm = (duty_sh>=1).
REQ-026 o_irq SHALL set on period-end and clear on i_irq_clr; simultaneous set and clear -> o_irq stays 1.

Reset
REQ-027 i_rst=1 SHALL immediately force state IDLE, count=0, slow_q=0, shadows=0, o_pwm=0, o_irq=0, o_busy=0, o_count=0.
REQ-028 Reset asserted mid-RUN SHALL abort the period without firing an interrupt; after release the block waits in IDLE for i_en.

Configuration
REQ-029 Macro PWM_TIMER_IRQ_EN: defined -> o_irq logic per REQ-026; undefined -> o_irq tied to 0, irq register and i_irq_clr logic removed, port list unchanged.

Verification
REQ-030 Divider ratio 4 (tick every 4 i_clk), period=5, duty=2, mode=0, en=1 -> o_pwm high 8 i_clk, low 12 i_clk, repeating; o_irq sets at every count 4->0 wrap.
REQ-031 mode=1, period=3, duty=1 -> o_pwm high 1 tick, low 2 ticks, then DONE, o_busy=0, o_irq=1; en low -> IDLE.
REQ-032 Change i_duty 2->4 mid-period (period=5) -> old duty holds until wrap, next period o_pwm high 4 ticks.
REQ-033 duty=0 -> o_pwm constant 0; duty=7 with period=5 -> o_pwm constant 1 while busy.
REQ-034 Assert i_rst at count=3 in RUN -> all outputs 0 same cycle, no irq; i_en=0 mid-RUN -> IDLE next cycle, count=0.
REQ-035 i_irq_clr coincident with period-end -> o_irq remains 1; without PWM_TIMER_IRQ_EN, o_irq stays 0 throughout REQ-030.

Source files
------------

// File: rtl/pwm_timer.sv
// PWM / one-shot timer advanced by rising edges of a divided clock sampled in the i_clk domain.
// Optional sticky period-end interrupt is built only when PWM_TIMER_IRQ_EN is defined.
module pwm_timer #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_slow_clk,
  input  logic             i_en,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_period,
  input  logic [WIDTH-1:0] i_duty,
  input  logic             i_irq_clr,
  output logic             o_pwm,
  output logic             o_irq,
  output logic [WIDTH-1:0] o_count,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic             slow_q;
  logic             tick;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic             mode_q, mode_d;
  logic             pwm_q, pwm_d;
  logic             period_end;

  // The divided clock is treated as plain data; a tick is its sampled rising edge.
  assign tick = i_slow_clk & ~slow_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      slow_q   <= 1'b0;
      count_q  <= '0;
      period_q <= '0;
      duty_q   <= '0;
      mode_q   <= 1'b0;
      pwm_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      slow_q   <= i_slow_clk;
      count_q  <= count_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      mode_q   <= mode_d;
      pwm_q    <= pwm_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    period_d   = period_q;
    duty_d     = duty_q;
    mode_d     = mode_q;
    period_end = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_en && (i_period != '0)) begin
          period_d = i_period;
          duty_d   = i_duty;
          mode_d   = i_mode;
          count_d  = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (!i_en) begin
          state_d = IDLE;
          count_d = '0;
        end else if (tick) begin
          if (count_q == (period_q - WIDTH'(1))) begin
            count_d    = '0;
            period_end = 1'b1;
            if (mode_q) begin
              state_d = DONE;
            end else begin
              // Shadows only follow the inputs at a period boundary.
              period_d = i_period;
              duty_d   = i_duty;
              mode_d   = i_mode;
            end
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end
      end
      DONE: begin
        if (!i_en) begin
          state_d = IDLE;
          count_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
    // Output is registered from the next-state view, so it equals (RUN && count < duty) of the flops.
    pwm_d = (state_d == RUN) && (count_d < duty_d);
  end

  assign o_pwm   = pwm_q;
  assign o_count = count_q;
  assign o_busy  = (state_q == RUN);

`ifdef PWM_TIMER_IRQ_EN
  logic irq_q;

  // A set in the same cycle as a clear wins.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= period_end | (irq_q & ~i_irq_clr);
    end
  end

  assign o_irq = irq_q;
`else
  logic irq_logic_unused;

  assign irq_logic_unused = i_irq_clr ^ period_end;
  assign o_irq            = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_timer.sv
// Directed self-checking bench for pwm_timer with a divide-by-4 slow clock.
// Interrupt expectations follow PWM_TIMER_IRQ_EN as seen by this compilation.
module tb_pwm_timer;

  localparam int WIDTH = 16;

`ifdef PWM_TIMER_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             slow_clk;
  logic             en;
  logic             mode;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] duty;
  logic             irq_clr;
  logic             pwm;
  logic             irq;
  logic [WIDTH-1:0] count;
  logic             busy;

  logic [1:0]       div_cnt;
  int               checks = 0;
  int               errors = 0;

  pwm_timer #(.WIDTH(WIDTH)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_slow_clk (slow_clk),
    .i_en       (en),
    .i_mode     (mode),
    .i_period   (period),
    .i_duty     (duty),
    .i_irq_clr  (irq_clr),
    .o_pwm      (pwm),
    .o_irq      (irq),
    .o_count    (count),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  // Slow clock: low, low, high, high per four i_clk cycles, changing on falling edges.
  initial begin
    div_cnt  = 2'd0;
    slow_clk = 1'b0;
    forever begin
      @(negedge clk);
      div_cnt  = div_cnt + 2'd1;
      slow_clk = div_cnt[1];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Returns right after the i_clk edge on which a tick was taken.
  task automatic sync_tick();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (div_cnt != 2'd2 && n < 8);
  endtask

  task automatic wait_count(input logic [WIDTH-1:0] v, input string tag);
    int n;
    n = 0;
    while (count !== v && n < 200) begin
      step();
      n++;
    end
    check({tag, "_reach"}, 32'(count === v), 32'd1);
  endtask

  // Counts consecutive sampled cycles with o_pwm at lvl, starting at the current sample.
  task automatic run_len(input logic lvl, output int len);
    len = 0;
    while (pwm === lvl && len < 400) begin
      len++;
      step();
    end
  endtask

  task automatic clear_irq();
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
  endtask

  initial begin
    int len;
    int hi;
    int lo;
    int n;
    int bad;

    rst     = 1'b1;
    en      = 1'b0;
    mode    = 1'b0;
    period  = '0;
    duty    = '0;
    irq_clr = 1'b0;
    repeat (3) step();
    check("rst_pwm", 32'(pwm), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    rst = 1'b0;
    step();

    // Zero period never leaves IDLE.
    en = 1'b1;
    repeat (8) step();
    check("period0_idle", 32'(busy), 32'd0);
    en = 1'b0;
    step();

    // Continuous PWM, period 5, duty 2: 8 cycles high, 12 low.
    period = 16'd5;
    duty   = 16'd2;
    mode   = 1'b0;
    sync_tick();
    en = 1'b1;
    step();
    check("run_busy", 32'(busy), 32'd1);
    check("run_pwm_start", 32'(pwm), 32'd1);
    run_len(1'b1, len);
    check("first_hi", 32'(len), 32'd7);
    run_len(1'b0, len);
    check("lo_a", 32'(len), 32'd12);
    run_len(1'b1, len);
    check("hi_b", 32'(len), 32'd8);
    run_len(1'b0, len);
    check("lo_b", 32'(len), 32'd12);

    clear_irq();
    check("irq_cleared", 32'(irq), 32'd0);
    wait_count(16'd4, "wrap4");
    n = 0;
    while (count === 16'd4 && n < 20) begin
      step();
      n++;
    end
    check("wrap_count", 32'(count), 32'd0);
    check("irq_wrap", 32'(irq), 32'(IRQ_ON));

    // Clear held across the wrap edge: set wins.
    clear_irq();
    wait_count(16'd4, "collide4");
    irq_clr = 1'b1;
    n = 0;
    while (count === 16'd4 && n < 20) begin
      step();
      n++;
    end
    irq_clr = 1'b0;
    check("collide_count", 32'(count), 32'd0);
    check("irq_set_clr_collide", 32'(irq), 32'(IRQ_ON));
    step();
    check("irq_sticky", 32'(irq), 32'(IRQ_ON));

    // Duty 2 -> 4 mid-period takes effect only after the wrap.
    wait_count(16'd2, "duty_chg");
    duty = 16'd4;
    run_len(1'b0, len);
    check("old_duty_lo", 32'(len), 32'd12);
    run_len(1'b1, len);
    check("new_duty_hi", 32'(len), 32'd16);
    run_len(1'b0, len);
    check("new_duty_lo", 32'(len), 32'd4);

    // Enable dropped mid-RUN.
    wait_count(16'd3, "en_drop");
    clear_irq();
    en = 1'b0;
    step();
    check("en0_busy", 32'(busy), 32'd0);
    check("en0_count", 32'(count), 32'd0);
    check("en0_pwm", 32'(pwm), 32'd0);
    check("en0_no_irq", 32'(irq), 32'd0);

    // Duty 0 never drives high.
    duty = 16'd0;
    en   = 1'b1;
    step();
    check("duty0_busy", 32'(busy), 32'd1);
    bad = 0;
    repeat (40) begin
      if (pwm !== 1'b0) bad++;
      step();
    end
    check("duty0_const", 32'(bad), 32'd0);
    en = 1'b0;
    step();

    // Duty above period stays high while busy.
    duty = 16'd7;
    en   = 1'b1;
    step();
    bad = 0;
    repeat (40) begin
      if (busy !== 1'b1 || pwm !== 1'b1) bad++;
      step();
    end
    check("duty7_const", 32'(bad), 32'd0);
    en = 1'b0;
    step();

    // Period 1 wraps every tick; count stays 0, output high.
    period = 16'd1;
    duty   = 16'd1;
    clear_irq();
    en = 1'b1;
    step();
    bad = 0;
    repeat (20) begin
      if (count !== 16'd0 || pwm !== 1'b1) bad++;
      step();
    end
    check("period1_const", 32'(bad), 32'd0);
    check("period1_irq", 32'(irq), 32'(IRQ_ON));
    en = 1'b0;
    step();

    // One-shot, period 3, duty 1.
    clear_irq();
    mode   = 1'b1;
    period = 16'd3;
    duty   = 16'd1;
    sync_tick();
    en = 1'b1;
    step();
    hi = 0;
    lo = 0;
    n  = 0;
    while (busy === 1'b1 && n < 100) begin
      if (pwm === 1'b1) hi++;
      else lo++;
      step();
      n++;
    end
    check("oneshot_hi", 32'(hi), 32'd3);
    check("oneshot_lo", 32'(lo), 32'd8);
    check("done_pwm", 32'(pwm), 32'd0);
    check("done_count", 32'(count), 32'd0);
    check("done_irq", 32'(irq), 32'(IRQ_ON));
    bad = 0;
    repeat (8) begin
      if (busy !== 1'b0 || pwm !== 1'b0) bad++;
      step();
    end
    check("done_hold", 32'(bad), 32'd0);
    en = 1'b0;
    step();
    en = 1'b1;
    step();
    check("restart_from_idle", 32'(busy), 32'd1);
    en = 1'b0;
    step();

    // Reset asserted at count 3 mid-RUN.
    mode   = 1'b0;
    period = 16'd5;
    duty   = 16'd4;
    clear_irq();
    en = 1'b1;
    wait_count(16'd3, "rst_mid");
    check("pre_reset_pwm", 32'(pwm), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_pwm", 32'(pwm), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_count", 32'(count), 32'd0);
    check("rst_mid_irq", 32'(irq), 32'd0);
    en = 1'b0;
    step();
    rst = 1'b0;
    repeat (10) step();
    check("post_rst_idle", 32'(busy), 32'd0);
    check("post_rst_no_irq", 32'(irq), 32'd0);
    en = 1'b1;
    step();
    check("post_rst_start", 32'(busy), 32'd1);
    en = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
